ahb_to_apb_bridge: RTL
======================

Name: ahb_to_apb_bridge

Overview:
AHB-Lite slave that converts each selected AHB transfer into one AMBA3 APB transfer (SETUP then ACCESS) with PREADY wait states and PSLVERR.
It sits directly downstream of one slave port of the ahb_lite_s3 interconnect, in place of a mem_ahb instance, and drives a single APB peripheral bus.
Read data and errors are returned as AHB data-phase responses.

Parameters:
P_ADDR_WIDTH, 16, width of PADDR; taken from HADDR[P_ADDR_WIDTH-1:0].

Ports:
HCLK        input   1   clock; all logic on rising edge
HRESET      input   1   asynchronous, active-high reset
HSEL        input   1   slave select from interconnect
HADDR       input   32  AHB address
HTRANS      input   2   AHB transfer type (NONSEQ=2, SEQ=3)
HWRITE      input   1   1 = write
HSIZE       input   3   transfer size (0 = byte, 1 = half, 2 = word)
HWDATA      input   32  write data (valid in data phase)
HREADYin    input   1   bus-wide HREADY
HRDATA      output  32  read data
HRESP       output  2   0 = OKAY, 1 = ERROR
HREADYout   output  1   this slave's ready
PADDR       output  P_ADDR_WIDTH  APB address
PSEL        output  1   APB select
PENABLE     output  1   APB enable
PWRITE      output  1   APB direction
PWDATA      output  32  APB write data
PSTRB       output  4   APB write strobes
PRDATA      input   32  APB read data
PREADY      input   1   APB ready
PSLVERR     input   1   APB error

Behaviour:
- Reset (asynchronous, immediate, legal mid-transfer):
  - state = IDLE; HREADYout = 1; HRESP = 0; HRDATA = 0.
  - PSEL = PENABLE = PWRITE = 0; PADDR = 0; PWDATA = 0; PSTRB = 0.
  - Any APB access in progress is abandoned; the peripheral sees PSEL fall.
- Accept condition: HSEL & HREADYin & HTRANS[1] sampled at a rising edge while HREADYout = 1.
  - On accept, register HADDR, HWRITE and HSIZE; next state = WAIT.
  - HTRANS IDLE/BUSY, or HSEL = 0, is ignored; HREADYout stays 1 and HRESP = OKAY.
- States and transitions; HREADYout and HRESP are registered outputs:
  - IDLE: HREADYout = 1. On accept -> WAIT.
  - WAIT: first data-phase cycle; HREADYout = 0.
    - If HSIZE > 2 -> ERR1; no APB access is made.
    - Else capture HWDATA into PWDATA (writes only) -> SETUP.
  - SETUP: PSEL = 1, PENABLE = 0; PADDR, PWRITE and PSTRB valid -> ACCESS.
  - ACCESS: PSEL = 1, PENABLE = 1; hold every APB output while PREADY = 0 (unbounded wait).
    - On PREADY = 1: deassert PSEL and PENABLE; latch HRDATA <= PRDATA on reads (HRDATA unchanged on writes).
    - PSLVERR = 1 -> ERR1; else -> DONE.
  - DONE: HREADYout = 1, HRESP = OKAY. The accept condition is evaluated here (back-to-back: -> WAIT), else -> IDLE.
  - ERR1: HREADYout = 0, HRESP = ERROR -> ERR2.
  - ERR2: HREADYout = 1, HRESP = ERROR. Accept is evaluated as in DONE. HRESP returns to OKAY in the next state.
- Latency with PREADY tied high: accept at edge N; HREADYout low for the WAIT/SETUP/ACCESS cycles; HREADYout = 1 in DONE, i.e. 3 wait states.
  - Each PREADY-low cycle adds exactly one wait state.
- PSTRB (writes only; always 0 on reads):
  - HSIZE 0: 4'b0001 << HADDR[1:0]
  - HSIZE 1: 4'b0011 << {HADDR[1],1'b0}
  - HSIZE 2: 4'b1111
- PADDR = registered HADDR[P_ADDR_WIDTH-1:0]. The unaligned low bits are passed through unchanged.
- PWDATA and PADDR hold their last values when PSEL = 0.

Test Plan:
- Write word 0xDEADBEEF to 0x0010, PREADY = 1:
  - Exactly one SETUP + ACCESS with PADDR = 0x0010, PWRITE = 1, PSTRB = 4'hF, PWDATA = 0xDEADBEEF.
  - HREADYout low 3 cycles, then OKAY.
- Read 0x0020 with PREADY low for 2 ACCESS cycles, PRDATA = 0x12345678:
  - HREADYout low 5 cycles; HRDATA = 0x12345678 with HREADYout = 1.
  - APB outputs stable throughout ACCESS.
- Byte write 0xAB at 0x0003, then halfword write at 0x0002: PSTRB = 4'b1000, then 4'b1100.
- PSLVERR = 1 on a write:
  - HREADYout = 0 / HRESP = 1, then HREADYout = 1 / HRESP = 1.
  - Next transfer returns OKAY.
- Handshake and select corner cases:
  - HSIZE = 3 request: two-cycle ERROR response, PSEL never asserted.
  - Back-to-back NONSEQ reads accepted in DONE: second SETUP starts 2 cycles after DONE.
  - HTRANS = BUSY or HSEL = 0: no APB activity.
- Assert HRESET during ACCESS: PSEL, PENABLE and HRESP drop to 0 immediately and HREADYout = 1; a new transfer after release completes normally.

Source files
------------

// File: rtl/ahb_to_apb_bridge.sv
// ahb_to_apb_bridge: AHB-Lite slave that turns each accepted transfer into one
// APB SETUP/ACCESS pair, returning read data and PSLVERR as AHB responses.
`default_nettype none

module ahb_to_apb_bridge #(
  parameter int P_ADDR_WIDTH = 16
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic                    HSEL,
  input  logic [31:0]             HADDR,
  input  logic [1:0]              HTRANS,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [31:0]             HWDATA,
  input  logic                    HREADYin,
  output logic [31:0]             HRDATA,
  output logic [1:0]              HRESP,
  output logic                    HREADYout,
  output logic [P_ADDR_WIDTH-1:0] PADDR,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [31:0]             PWDATA,
  output logic [3:0]              PSTRB,
  input  logic [31:0]             PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR1   = 3'd5,
    ST_ERR2   = 3'd6
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic                    accept;
  logic [P_ADDR_WIDTH-1:0] addr_q;
  logic [1:0]              lane_q;
  logic                    write_q;
  logic [2:0]              size_q;
  logic [3:0]              strb;
  logic                    start_apb;
  logic                    unused_inputs;

  // HTRANS[0] only distinguishes SEQ from NONSEQ, which this slave treats alike.
  assign unused_inputs = &{1'b0, HTRANS[0], HADDR};

  assign accept    = HSEL & HREADYin & HTRANS[1] & HREADYout;
  assign start_apb = (state == ST_WAIT) && (state_next == ST_SETUP);

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR2: state_next = accept ? ST_WAIT : ST_IDLE;
      ST_WAIT:                   state_next = (size_q > 3'd2) ? ST_ERR1 : ST_SETUP;
      ST_SETUP:                  state_next = ST_ACCESS;
      ST_ACCESS: begin
        if (PREADY) begin
          state_next = PSLVERR ? ST_ERR1 : ST_DONE;
        end
      end
      ST_ERR1:                   state_next = ST_ERR2;
      default:                   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    strb = 4'b0000;
    case (size_q)
      3'd0:    strb = 4'b0001 << lane_q;
      3'd1:    strb = 4'b0011 << {lane_q[1], 1'b0};
      3'd2:    strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
    if (!write_q) begin
      strb = 4'b0000;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Handshake outputs are registered from the next state so they change with it.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      addr_q    <= '0;
      lane_q    <= 2'b00;
      write_q   <= 1'b0;
      size_q    <= 3'd0;
      HREADYout <= 1'b1;
      HRESP     <= 2'b00;
      HRDATA    <= 32'h0;
      PADDR     <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PWDATA    <= 32'h0;
      PSTRB     <= 4'b0000;
    end else begin
      if (accept) begin
        addr_q  <= HADDR[P_ADDR_WIDTH-1:0];
        lane_q  <= HADDR[1:0];
        write_q <= HWRITE;
        size_q  <= HSIZE;
      end
      HREADYout <= state_next inside {ST_IDLE, ST_DONE, ST_ERR2};
      HRESP     <= {1'b0, state_next inside {ST_ERR1, ST_ERR2}};
      PSEL      <= state_next inside {ST_SETUP, ST_ACCESS};
      PENABLE   <= (state_next == ST_ACCESS);
      if (start_apb) begin
        PADDR  <= addr_q;
        PWRITE <= write_q;
        PSTRB  <= strb;
        if (write_q) begin
          PWDATA <= HWDATA;
        end
      end
      if ((state == ST_ACCESS) && PREADY && !write_q) begin
        HRDATA <= PRDATA;
      end
    end
  end

endmodule

`default_nettype wire
